// File: rtl/booth_mult_4bit_pkg.sv
// Shared arithmetic definitions for the Booth multiplier: FSM encoding,
// Booth recoding pairs and operand/product widths.
package booth_mult_4bit_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_4bit_if.sv
// Start/busy/done handshake and operand/product bus of the Booth multiplier.
interface booth_mult_4bit_if
  import booth_mult_4bit_pkg::*;
;

  logic              start;
  logic [OP_W-1:0]   multiplicand;
  logic [OP_W-1:0]   multiplier;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/parallel_add_sub_4bit.sv
// Combinational 4-bit ripple add/subtract (sign=1 subtracts b); exposes the
// carry out of every bit so callers can derive signed overflow.
module parallel_add_sub_4bit
  import booth_mult_4bit_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            sign,
  output logic [OP_W-1:0] s,
  output logic [OP_W-1:0] c_out
);

  logic [OP_W-1:0] b_eff;
  logic [OP_W:0]   carry;

  // Ripple chain; subtraction is a + ~b + 1 via the carry-in.
  always_comb begin
    b_eff    = b ^ {OP_W{sign}};
    carry    = '0;
    carry[0] = sign;
    s        = '0;
    for (int i = 0; i < OP_W; i++) begin
      s[i]       = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

  assign c_out = carry[OP_W:1];

endmodule

// File: rtl/booth_mult_4bit.sv
// Sequential signed 4x4 radix-2 Booth multiplier: one add/sub-then-shift step
// per clock through parallel_add_sub_4bit, with a start/busy/done handshake.
module booth_mult_4bit
  import booth_mult_4bit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  booth_mult_4bit_if.slave   bus
);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   acc, acc_nx;
  logic [WIDTH-1:0]   mq, mq_nx;
  logic               q_m1, q_m1_nx;
  logic [WIDTH-1:0]   mcand, mcand_nx;
  logic [2:0]         cnt, cnt_nx;
  logic               busy, done;
  logic [2*WIDTH-1:0] product;

  logic [1:0]         booth;
  logic               sign;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   c_out;
  logic [WIDTH-1:0]   res;
  logic               msb;

  assign booth = {mq[0], q_m1};
  assign sign  = (booth == BOOTH_SUB);

  parallel_add_sub_4bit u_add_sub (
    .a     (acc),
    .b     (mcand),
    .sign  (sign),
    .s     (sum),
    .c_out (c_out)
  );

  // Next-state and datapath; the shifted-in bit uses the overflow-corrected
  // sign so the 4-bit adder still yields the true 5-bit sign (M = -8).
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    mq_nx    = mq;
    q_m1_nx  = q_m1;
    mcand_nx = mcand;
    cnt_nx   = cnt;
    res      = acc;
    msb      = acc[WIDTH-1];
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nx   = '0;
          mq_nx    = bus.multiplier;
          q_m1_nx  = 1'b0;
          mcand_nx = bus.multiplicand;
          cnt_nx   = 3'd0;
          state_nx = CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
        case (booth)
          BOOTH_ADD, BOOTH_SUB: begin
            res = sum;
            msb = sum[WIDTH-1] ^ (c_out[WIDTH-1] ^ c_out[WIDTH-2]);
          end
          default: begin
            res = acc;
            msb = acc[WIDTH-1];
          end
        endcase
        acc_nx  = {msb, res[WIDTH-1:1]};
        mq_nx   = {res[0], mq[WIDTH-1:1]};
        q_m1_nx = mq[0];
        if (cnt == 3'(WIDTH - 1)) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mq      <= '0;
      q_m1    <= 1'b0;
      mcand   <= '0;
      cnt     <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      mq      <= mq_nx;
      q_m1    <= q_m1_nx;
      mcand   <= mcand_nx;
      cnt     <= cnt_nx;
      busy    <= (state == CALC);
      done    <= (state == DONE);
      if (state == DONE) begin
        product <= {acc, mq};
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;

endmodule

// File: tb/tb_booth_mult_4bit.sv
// Scoreboard bench for booth_mult_4bit: expected products come from plain
// signed multiplication and are checked by an independent done monitor.
module tb_booth_mult_4bit;

  typedef struct {
    logic [7:0] prod;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  exp_t sb[$];
  exp_t e;

  booth_mult_4bit_if bus ();

  booth_mult_4bit #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_mult(input logic [3:0] m, input logic [3:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[7:0];
  endfunction

  // Called at a negedge; the next posedge accepts, done is seen 6 negedges on.
  task automatic issue(input logic [3:0] m, input logic [3:0] q);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    sb.push_back('{ref_mult(m, q), cyc + 6});
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = 4'($urandom);
    bus.multiplier   = 4'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done expected done within 20 cycles (cycle %0d)", cyc);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("product", 32'(bus.product), 32'(e.prod));
          chk("latency", 32'(cyc), 32'(e.due));
          chk("busy_cycles", 32'(busy_cnt), 32'd4);
          chk("busy_with_done", 32'(bus.busy), 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    logic [3:0] dm [8] = '{4'd3, 4'hD, 4'd5, 4'h8, 4'h8, 4'd0, 4'd7, 4'd2};
    logic [3:0] dq [8] = '{4'd5, 4'd5, 4'hD, 4'h8, 4'd7, 4'hF, 4'd7, 4'd6};

    bus.start        = 1'b0;
    bus.multiplicand = 4'd0;
    bus.multiplier   = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operand pairs, issued back-to-back on each done.
    for (int i = 0; i < 8; i++) begin
      issue(dm[i], dq[i]);
      wait_done();
    end

    // Random operands.
    for (int i = 0; i < 20; i++) begin
      issue(4'($urandom), 4'($urandom));
      wait_done();
    end

    // start pulses during CALC and DONE, with new operands, are ignored.
    @(negedge clk);
    issue(4'd3, 4'd5);
    bus.multiplicand = 4'd7;
    bus.multiplier   = 4'd7;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
    repeat (3) @(negedge clk);
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
    repeat (8) @(negedge clk);

    // start held high through DONE is taken at the first IDLE edge after done.
    bus.multiplicand = 4'hA;
    bus.multiplier   = 4'd3;
    bus.start        = 1'b1;
    sb.push_back('{ref_mult(4'hA, 4'd3), cyc + 6});
    sb.push_back('{ref_mult(4'hA, 4'd3), cyc + 12});
    @(negedge clk);
    wait_done();
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset in the second CALC cycle aborts without a done pulse.
    issue(4'd3, 4'd5);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_product", 32'(bus.product), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(4'd2, 4'hC);
    wait_done();
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mult_4bit.md
# booth_mult_4bit

Sequential signed 4×4 multiplier using radix-2 Booth recoding. It consumes the existing combinational `parallel_add_sub_4bit` block as its add/subtract datapath, running one add-or-subtract-then-shift step per clock. It sits downstream of operand registers and returns an 8-bit two's-complement product with a start/busy/done handshake. It is the first sequential consumer of the add/sub block in the arithmetic track.

## Interface
- `WIDTH`, default 4: operand width. Only 4 is legal, because it must match `parallel_add_sub_4bit`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `multiplicand`  in  4  signed operand M; captured when start is accepted
- `multiplier`  in  4  signed operand Q; captured when start is accepted
- `busy`  out  1  high during the CALC state
- `done`  out  1  one-cycle pulse when the product becomes valid
- `product`  out  8  signed M×Q; held stable until the next accepted start

## Operation
- Registers:
  - A[3:0] accumulator
  - Q[3:0]
  - q_m1 (the Booth extra bit)
  - M[3:0]
  - cnt[2:0]
  - product[7:0]
- FSM states:
  - IDLE: if start=1, load A=0, Q=multiplier, q_m1=0, M=multiplicand, cnt=0, then go to CALC.
  - CALC: perform one Booth step per cycle. After the step where cnt==3, go to DONE. Otherwise cnt+1.
  - DONE: product={A,Q}, done=1 for this cycle, then go to IDLE unconditionally.
- Booth step, driven by {Q[0],q_m1}:
  - 01: A+M, with sub-module sign=0.
  - 10: A−M, with sub-module sign=1.
  - 00 or 11: pass A unchanged. The sub-module result is ignored.
- Sub-module wiring:
  - a=A, b=M, sign per the step rule above.
  - s is the 4-bit result.
  - c_out is the per-bit carry vector: c_out[3] is the carry out of the MSB, c_out[2] is the carry into the MSB.
- Overflow-corrected sign:
  - ovf = c_out[3] ^ c_out[2], valid only on an add/sub step.
  - Shift-in bit msb = s[3] ^ ovf on an add/sub step, A[3] on a pass step.
  - This gives the true 5-bit sign without widening the adder, so M = −8 is handled.
- Arithmetic right shift of {msb, R, Q, q_m1}, where R is the new A value:
  - A ← {msb, R[3:1]}
  - Q ← {R[0], Q[3:1]}
  - q_m1 ← Q[0]
- Boundaries:
  - start while busy, or while in DONE, is ignored. No queueing.
  - Operands may change after acceptance without affecting the result.
  - Product range is −56..+64. All values fit in 8 bits with no saturation.

## Timing
- Reset value of every output is 0: busy=0, done=0, product=8'h00. State is IDLE. All internal registers clear.
- Reset asserted mid-CALC aborts immediately. done is not pulsed and product returns to 0.
- Accept at edge T (start=1 in IDLE). CALC spans the cycles after edges T+1..T+4. done=1 and product is valid in the cycle after edge T+5.
- Latency is 5 clocks from accepting edge to done. Throughput is one product per 6 cycles (IDLE re-entry included).
- Back-to-back operation: start held high through DONE is accepted at the first IDLE edge after done.
- busy=1 exactly 4 cycles per operation. busy is never high at the same time as done.

## Structure
- Shared arithmetic package holds:
  - state encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2
  - Booth recoding constants: BOOTH_ADD=2'b01, BOOTH_SUB=2'b10
- One sub-module instance: `parallel_add_sub_4bit` (existing). No new sub-modules.
- FSM, shift register and counter stay in `booth_mult_4bit`.

## Test plan
- Reset, then M=3, Q=5, start → done after 5 clocks, product=8'h0F. busy high for exactly 4 cycles.
- M=−3 (4'b1101), Q=5 → product=8'hF1 (−15). M=5, Q=−3 → product=8'hF1.
- M=−8, Q=−8 → product=8'h40 (+64), exercising the ovf sign correction. M=−8, Q=7 → product=8'hC8 (−56).
- M=0, Q=−1 → product=8'h00. M=7, Q=7 → product=8'h31 (49).
- start pulsed again with different operands during CALC → ignored. Result matches the first operands, and only one done pulse occurs.
- rst asserted at the second CALC cycle → outputs 0 and no done pulse. A following 2×−4 operation yields product=8'hF8.
